// File: rtl/log_pkg.sv
// Shared types and constants for the log writer: FSM states, record slot layout and index field positions.
// Record length depends on LOG_WRITER_TIMESTAMP_EN.
package log_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_RD_IX   = 3'd2,
    ST_WR_SLOT = 3'd3,
    ST_WR_IX   = 3'd4,
    ST_DONE    = 3'd5
  } log_state_e;

  localparam int SLOT_CODE  = 0;
  localparam int SLOT_CAUSE = 1;
  localparam int SLOT_ADDR  = 2;
  localparam int SLOT_TS    = 6;

`ifdef LOG_WRITER_TIMESTAMP_EN
  localparam int LOG_REC_LEN = 10;
`else
  localparam int LOG_REC_LEN = 6;
`endif

  localparam int IX_PUT_LSB = 16;
  localparam int IX_GET_LSB = 0;

  // Byte carried by a given record slot; multi-byte fields go out little-endian.
  function automatic logic [7:0] rec_byte(input logic [3:0]  slot,
                                          input logic [7:0]  code,
                                          input logic [7:0]  cause,
                                          input logic [31:0] addr,
                                          input logic [31:0] ts);
    logic [7:0] b;
    case (slot)
      4'(SLOT_CODE):     b = code;
      4'(SLOT_CAUSE):    b = cause;
      4'(SLOT_ADDR):     b = addr[7:0];
      4'(SLOT_ADDR + 1): b = addr[15:8];
      4'(SLOT_ADDR + 2): b = addr[23:16];
      4'(SLOT_ADDR + 3): b = addr[31:24];
      4'(SLOT_TS):       b = ts[7:0];
      4'(SLOT_TS + 1):   b = ts[15:8];
      4'(SLOT_TS + 2):   b = ts[23:16];
      4'(SLOT_TS + 3):   b = ts[31:24];
      default:           b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/log_tscnt.sv
// Free-running 32-bit cycle counter with a sample strobe; the sampled value is held until the next strobe.
// Used only when LOG_WRITER_TIMESTAMP_EN is defined.
module log_tscnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_i,
  output logic [31:0] ts_o
);

  logic [31:0] cnt_q;
  logic [31:0] ts_q;

  // Counter wraps naturally; the sample captures the count seen in the accepting cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
      ts_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (sample_i) begin
        ts_q <= cnt_q;
      end else begin
        ts_q <= ts_q;
      end
    end
  end

  assign ts_o = ts_q;

endmodule

// File: rtl/log_writer.sv
// Bus master that turns monitor events into log buffer entries: read indices, write the record slots,
// then publish by writing the advanced indices. Optional timestamps via LOG_WRITER_TIMESTAMP_EN.
module log_writer
  import log_pkg::*;
#(
  parameter int NUM_ENTRIES = 32,
  parameter int IX_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        evt_req,
  input  logic [7:0]  evt_code,
  input  logic [7:0]  evt_cause,
  input  logic [31:0] evt_addr,
  output logic        evt_ack,
  output logic        lb_req,
  input  logic        lb_gnt,
  output logic        lb_stb,
  output logic        lb_we,
  output logic        lb_addr,
  output logic [31:0] lb_dout,
  input  logic [31:0] lb_din,
  input  logic        lb_ack,
  output logic [7:0]  ovwr_cnt,
  output logic        busy
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);

  log_state_e       state_q, state_d;
  logic [7:0]       code_q, cause_q;
  logic [31:0]      addr_q;
  logic [PTR_W-1:0] put_q, put_d, get_q, get_d;
  logic [PTR_W-1:0] new_put_s, new_get_s;
  logic [3:0]       slot_q, slot_d;
  logic [7:0]       ovwr_q, ovwr_d;
  logic             accept_s, bus_phase_s, acc_s, wrap_s, ix_bad_s;
  logic [IX_W-1:0]  put_raw_s, get_raw_s;
  logic [31:0]      ts_s, ix_word_s;

  assign accept_s    = (state_q == ST_IDLE) && evt_req;
  assign bus_phase_s = (state_q == ST_RD_IX) || (state_q == ST_WR_SLOT) || (state_q == ST_WR_IX);
  assign acc_s       = bus_phase_s && lb_gnt && lb_ack;

  assign put_raw_s = lb_din[IX_PUT_LSB +: IX_W];
  assign get_raw_s = lb_din[IX_GET_LSB +: IX_W];
  assign ix_bad_s  = (32'(put_raw_s) >= 32'(NUM_ENTRIES)) || (32'(get_raw_s) >= 32'(NUM_ENTRIES));

  // Ring is full when advancing put would land on get: drop the oldest entry.
  assign new_put_s = put_q + PTR_W'(1);
  assign wrap_s    = (new_put_s == get_q);
  assign new_get_s = wrap_s ? (get_q + PTR_W'(1)) : get_q;
  assign ix_word_s = {16'(new_put_s), 16'(new_get_s)};

`ifdef LOG_WRITER_TIMESTAMP_EN
  log_tscnt u_tscnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_i (accept_s),
    .ts_o     (ts_s)
  );
`else
  assign ts_s = 32'd0;
`endif

  // State, index and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      put_q   <= '0;
      get_q   <= '0;
      slot_q  <= 4'd0;
      ovwr_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      put_q   <= put_d;
      get_q   <= get_d;
      slot_q  <= slot_d;
      ovwr_q  <= ovwr_d;
    end
  end

  // Event fields are frozen at acceptance so later input changes cannot corrupt the record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= 8'd0;
      cause_q <= 8'd0;
      addr_q  <= 32'd0;
    end else if (accept_s) begin
      code_q  <= evt_code;
      cause_q <= evt_cause;
      addr_q  <= evt_addr;
    end else begin
      code_q  <= code_q;
      cause_q <= cause_q;
      addr_q  <= addr_q;
    end
  end

  // Next-state logic; without grant or ack every state simply holds.
  always_comb begin
    state_d = state_q;
    put_d   = put_q;
    get_d   = get_q;
    slot_d  = slot_q;
    ovwr_d  = ovwr_q;
    case (state_q)
      ST_IDLE: begin
        if (evt_req) state_d = ST_REQ;
        else         state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (lb_gnt) state_d = ST_RD_IX;
        else        state_d = ST_REQ;
      end
      ST_RD_IX: begin
        if (acc_s) begin
          put_d   = ix_bad_s ? '0 : put_raw_s[PTR_W-1:0];
          get_d   = ix_bad_s ? '0 : get_raw_s[PTR_W-1:0];
          slot_d  = 4'd0;
          state_d = ST_WR_SLOT;
        end else begin
          state_d = ST_RD_IX;
        end
      end
      ST_WR_SLOT: begin
        if (acc_s && (slot_q == 4'(LOG_REC_LEN - 1))) begin
          slot_d  = 4'd0;
          state_d = ST_WR_IX;
        end else if (acc_s) begin
          slot_d  = slot_q + 4'd1;
        end else begin
          slot_d  = slot_q;
        end
      end
      ST_WR_IX: begin
        if (acc_s) begin
          put_d   = new_put_s;
          get_d   = new_get_s;
          if (wrap_s && (ovwr_q != 8'hFF)) ovwr_d = ovwr_q + 8'd1;
          else                             ovwr_d = ovwr_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WR_IX;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus controls decode from state; strobe only while granted.
  always_comb begin
    lb_req  = 1'b0;
    lb_we   = 1'b0;
    lb_addr = 1'b0;
    lb_dout = 32'd0;
    case (state_q)
      ST_REQ: lb_req = 1'b1;
      ST_RD_IX: begin
        lb_req  = 1'b1;
        lb_addr = 1'b1;
      end
      ST_WR_SLOT: begin
        lb_req  = 1'b1;
        lb_we   = 1'b1;
        lb_dout = {24'd0, rec_byte(slot_q, code_q, cause_q, addr_q, ts_s)};
      end
      ST_WR_IX: begin
        lb_req  = 1'b1;
        lb_we   = 1'b1;
        lb_addr = 1'b1;
        lb_dout = ix_word_s;
      end
      default: lb_req = 1'b0;
    endcase
  end

  assign lb_stb   = bus_phase_s && lb_gnt;
  assign evt_ack  = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign ovwr_cnt = ovwr_q;

endmodule
